// File: rtl/graphite_cmd_encoder_if.sv
// graphite_cmd_encoder_if: request side and command-stream side of the graphite command encoder.
interface graphite_cmd_encoder_if #(parameter int CMD_STREAM_WIDTH = 16);
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [1:0]                  req_op_i;
    logic [11:0]                 req_x0_i, req_y0_i, req_x1_i, req_y1_i, req_x2_i, req_y2_i;
    logic [11:0]                 req_u0_i, req_v0_i, req_u1_i, req_v1_i, req_u2_i, req_v2_i;
    logic [11:0]                 req_color_i;
    logic                        cmd_axis_tvalid_o;
    logic                        cmd_axis_tready_i;
    logic [CMD_STREAM_WIDTH-1:0] cmd_axis_tdata_o;
    logic                        busy_o;
    logic                        done_o;
    modport slave (
        input  req_valid_i, req_op_i, req_x0_i, req_y0_i, req_x1_i, req_y1_i, req_x2_i, req_y2_i,
               req_u0_i, req_v0_i, req_u1_i, req_v1_i, req_u2_i, req_v2_i, req_color_i, cmd_axis_tready_i,
        output req_ready_o, cmd_axis_tvalid_o, cmd_axis_tdata_o, busy_o, done_o
    );
    modport master (
        output req_valid_i, req_op_i, req_x0_i, req_y0_i, req_x1_i, req_y1_i, req_x2_i, req_y2_i,
               req_u0_i, req_v0_i, req_u1_i, req_v1_i, req_u2_i, req_v2_i, req_color_i, cmd_axis_tready_i,
        input  req_ready_o, cmd_axis_tvalid_o, cmd_axis_tdata_o, busy_o, done_o
    );
endinterface

// File: rtl/graphite_cmd_encoder.sv
// graphite_cmd_encoder: turns CLEAR/LINE/TRIANGLE requests into a registered stream of
// {opcode, payload} command words, optionally skipping SET words the decoder already holds.
module graphite_cmd_encoder #(
    parameter int CMD_STREAM_WIDTH   = 16,
    parameter bit SUPPRESS_REDUNDANT = 1'b1
) (
    input logic                   clk,
    input logic                   reset_i,
    graphite_cmd_encoder_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t                      state_q, state_d;
    logic [3:0]                  step_q, step_d, nstep, nopc, cur_opc;
    logic [1:0]                  op_q, op_d, nop;
    logic [11:0]                 fld_q[13], fld_d[13], src[13], shadow_q[13], shadow_d[13];
    logic [12:0]                 shv_q, shv_d;
    logic                        tvalid_q, tvalid_d, done_q, done_d;
    logic [CMD_STREAM_WIDTH-1:0] tdata_q, tdata_d;
    logic                        accept, hs, last, skip, load;
    logic [11:0]                 npay;

    function automatic logic [3:0] opcode_of(input logic [1:0] op, input logic [3:0] step);
        return op == 2'd0 ? (step == 4'd0 ? 4'd12 : 4'd13) :
               op == 2'd1 ? (step < 4'd4 ? step : (step == 4'd4 ? 4'd12 : 4'd14)) :
               (step < 4'd13 ? step : 4'd15);
    endfunction

    // The word for the next step is prepared one cycle ahead, so outputs come straight from flops.
    always_comb begin
        accept  = state_q == IDLE && bus.req_valid_i;
        hs      = tvalid_q && bus.cmd_axis_tready_i;
        cur_opc = opcode_of(op_q, step_q);
        last    = step_q == (op_q == 2'd0 ? 4'd1 : op_q == 2'd1 ? 4'd5 : 4'd13);
        src     = fld_q;
        if (accept)
            src = '{bus.req_x0_i, bus.req_y0_i, bus.req_x1_i, bus.req_y1_i, bus.req_x2_i, bus.req_y2_i,
                    bus.req_u0_i, bus.req_v0_i, bus.req_u1_i, bus.req_v1_i, bus.req_u2_i, bus.req_v2_i,
                    bus.req_color_i};
        nop      = accept ? bus.req_op_i : op_q;
        nstep    = accept ? 4'd0 : step_q + 4'd1;
        nopc     = opcode_of(nop, nstep);
        npay     = nopc < 4'd13 ? src[nopc] : 12'h000;
        skip     = SUPPRESS_REDUNDANT && nopc < 4'd13 && shv_q[nopc] && shadow_q[nopc] == npay;
        load     = accept ? bus.req_op_i != 2'd3 : state_q == EMIT && (hs ? !last : !tvalid_q);
        state_d  = state_q;
        step_d   = step_q;
        op_d     = op_q;
        fld_d    = fld_q;
        shadow_d = shadow_q;
        shv_d    = shv_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        done_d   = accept && bus.req_op_i == 2'd3;
        if (accept) begin
            op_d    = bus.req_op_i;
            fld_d   = src;
            step_d  = 4'd0;
            state_d = bus.req_op_i == 2'd3 ? IDLE : EMIT;
        end
        if (hs && cur_opc < 4'd13) begin
            shadow_d[cur_opc] = tdata_q[11:0];
            shv_d[cur_opc]    = 1'b1;
        end
        if (hs && last) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            done_d   = 1'b1;
        end
        if (load) begin
            step_d   = nstep;
            tvalid_d = !skip;
            tdata_d  = {nopc, npay};
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            step_q   <= '0;
            op_q     <= '0;
            fld_q    <= '{default: '0};
            shadow_q <= '{default: '0};
            shv_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            fld_q    <= fld_d;
            shadow_q <= shadow_d;
            shv_q    <= shv_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            done_q   <= done_d;
        end
    end

    assign bus.req_ready_o       = state_q == IDLE;
    assign bus.busy_o            = state_q != IDLE;
    assign bus.cmd_axis_tvalid_o = tvalid_q;
    assign bus.cmd_axis_tdata_o  = tdata_q;
    assign bus.done_o            = done_q;
endmodule

// File: doc/graphite_cmd_encoder.md
GRAPHITE_CMD_ENCODER -- requirements
Module: graphite_cmd_encoder

Interface
REQ-001 The block SHALL have parameter CMD_STREAM_WIDTH, default 16, giving the command word width; only 16 is supported.
REQ-002 The block SHALL have parameter SUPPRESS_REDUNDANT, default 1; when 1, redundant SET words are skipped.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i  in  1  primitive request valid.
REQ-006 req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at clock edge.
REQ-007 req_op_i  in  2  0=CLEAR, 1=LINE, 2=TRIANGLE, 3=reserved.
REQ-008 req_x0_i, req_y0_i, req_x1_i, req_y1_i, req_x2_i, req_y2_i  in  12 each  vertex coordinates, two's complement.
REQ-009 req_u0_i, req_v0_i, req_u1_i, req_v1_i, req_u2_i, req_v2_i  in  12 each  texture coordinates.
REQ-010 req_color_i  in  12  color, 4 bits per channel.
REQ-011 cmd_axis_tvalid_o  out  1  AXI-stream master valid.
REQ-012 cmd_axis_tready_i  in  1  AXI-stream master ready.
REQ-013 cmd_axis_tdata_o  out  CMD_STREAM_WIDTH  command word {opcode[15:12], payload[11:0]}.
REQ-014 busy_o  out  1  high whenever state is not IDLE.
REQ-015 done_o  out  1  one-cycle pulse when a request completes.

Function
REQ-016 Opcodes SHALL match the graphite command decoder: 0 X0, 1 Y0, 2 X1, 3 Y1, 4 X2, 5 Y2, 6 U0, 7 V0, 8 U1, 9 V1, 10 U2, 11 V2, 12 COLOR, 13 CLEAR, 14 DRAW_LINE, 15 DRAW_TRIANGLE.
REQ-017 SET word payloads SHALL be the captured 12-bit field unchanged; CLEAR, DRAW_LINE and DRAW_TRIANGLE payloads SHALL be 12'h000.
REQ-018 Sequences SHALL be:
- CLEAR: COLOR, CLEAR.
- LINE: X0, Y0, X1, Y1, COLOR, DRAW_LINE.
- TRIANGLE: X0, Y0, X1, Y1, X2, Y2, U0, V0, U1, V1, U2, V2, COLOR, DRAW_TRIANGLE.
REQ-019 The FSM SHALL have states IDLE and EMIT, plus a 4-bit step index.
REQ-020 req_ready_o SHALL equal (state==IDLE); on acceptance, all req_* fields SHALL be registered, step SHALL be set to 0, and state SHALL go to EMIT; for op 3, state SHALL stay IDLE and done_o SHALL pulse the next cycle.
REQ-021 In EMIT, a SET step SHALL be skippable when SUPPRESS_REDUNDANT=1, that opcode's shadow register is valid, and the shadow equals the captured payload.
REQ-022 A skippable step SHALL hold tvalid low for one cycle and then advance the step.
REQ-023 A non-skippable step SHALL drive tvalid high with the step word; step SHALL advance only on tvalid && tready.
REQ-024 Draw and CLEAR opcodes SHALL never be skipped.
REQ-025 cmd_axis_tvalid_o and cmd_axis_tdata_o SHALL depend only on registers, with no combinational path from cmd_axis_tready_i or req_*.
REQ-026 Once tvalid is high, tvalid and tdata SHALL be held stable until the handshake.
REQ-027 On each SET handshake, the block SHALL write the payload into that opcode's shadow register and mark it valid.
REQ-028 On the final-word handshake, state SHALL go to IDLE and done_o SHALL be 1 for exactly the following cycle, during which req_ready_o is also 1.
REQ-029 Throughput SHALL be one word per cycle with tready held high and no skips; the first tvalid SHALL appear in the cycle after acceptance.
REQ-030 tready may toggle arbitrarily, including when tvalid is low; the block SHALL ignore tready while tvalid is low.

Reset
REQ-031 While reset_i=0 (asynchronously), the block SHALL force: state=IDLE, step=0, cmd_axis_tvalid_o=0, cmd_axis_tdata_o=0, done_o=0, busy_o=0, req_ready_o=1, all shadow valid bits=0.
REQ-032 Reset mid-sequence SHALL abandon the sequence; the next request SHALL emit all of its SET words.

Verification
REQ-033 After reset, TRIANGLE with x0..y2=1..6, u0..v2=7..12, color=0xABC, tready=1 -> 14 consecutive words 0x0001, 0x1002, ... 0xB00C, 0xCABC, 0xF000; done_o pulses one cycle after the last word.
REQ-034 The same TRIANGLE repeated with SUPPRESS_REDUNDANT=1 -> 13 bubble cycles, then only 0xF000; with SUPPRESS_REDUNDANT=0 -> all 14 words again.
REQ-035 LINE (x0=5, y0=6, x1=100, y1=7, color=0x0F0) with tready low for 5 cycles during word 3 -> tdata held at 0x2064 with tvalid high throughout; output order 0x0005, 0x1006, 0x2064, 0x3007, 0xC0F0, 0xE000.
REQ-036 CLEAR with color=0x123 -> 0xC123, 0xD000; busy_o high from acceptance until the final handshake.
REQ-037 reset_i low mid-LINE -> tvalid drops without waiting for a clock edge; the next identical LINE emits all 6 words.
REQ-038 req_op_i=3 -> no tvalid; done_o pulses one cycle later; req_ready_o remains 1.
